// File: rtl/pipe_mem_responder_if.sv
// Request/response bundle between a pipeline cache port (imem or dmem) and pipe_mem_responder.
// Request: ready_in (responder -> requester), valid_in, addr_in, op_in (0 read / 1 write), write_data_in.
// Response: ready_out (requester -> responder), valid_out, data_out.
// master = requester side, slave = responder side.
interface pipe_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ready_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] addr_in;
  logic                  op_in;
  logic [DATA_WIDTH-1:0] write_data_in;
  logic                  ready_out;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  ready_in, valid_out, data_out,
    output valid_in, addr_in, op_in, write_data_in, ready_out
  );

  modport slave (
    input  valid_in, addr_in, op_in, write_data_in, ready_out,
    output ready_in, valid_out, data_out
  );
endinterface

// File: rtl/pipe_mem_responder.sv
// Word memory answering in-order reads through a delay line and a response FIFO; writes are silent.
// Latency: read accepted at edge T is visible on valid_out after edge T+LATENCY-1 (empty FIFO).
// Backpressure: ready_in is a registered credit check (outstanding reads < RESP_DEPTH); ready_out pops.
// Ports: clk, reset (async, active-high), bus (pipe_mem_responder_if.slave: request + response channels).

// Small generic FIFO: registered occupancy, pointers wrap modulo DEPTH (DEPTH power of two).
// Latency: pushed entry is at the head after the push edge when the FIFO was empty.
// Backpressure: the owner must not push when full unless popping on the same edge.
module pmr_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         head_vld,
  output logic [W-1:0] head_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          pop;

  assign head_vld = (cnt_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign pop      = head_vld & pop_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_vld) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push_vld) - (PW+1)'(pop);
    end
  end

  // Storage needs no reset: occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module pipe_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 10,
  parameter int LATENCY    = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  pipe_mem_responder_if.slave bus
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem_q [2**INDEX_BITS];
  logic [INDEX_BITS-1:0] idx;
  logic                  acc;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  push_vld;
  logic [DATA_WIDTH-1:0] push_dat;
  logic                  head_vld;
  logic [DATA_WIDTH-1:0] head_dat;
  logic [CW-1:0]         out_q;
  logic [CW-1:0]         out_d;
  logic                  rdy_q;
  logic                  rdy_d;
  logic                  unused_addr_bits;

  // Byte offset and bits above the index are don't-care: addresses wrap.
  assign idx              = bus.addr_in[INDEX_BITS+1:2];
  assign unused_addr_bits = ^{bus.addr_in[DATA_WIDTH-1:INDEX_BITS+2], bus.addr_in[1:0]};

  assign acc    = bus.valid_in & rdy_q;
  assign acc_rd = acc & ~bus.op_in;
  assign acc_wr = acc & bus.op_in;
  assign pop    = head_vld & bus.ready_out;
  assign rd_dat = mem_q[idx];

  // Array is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (acc_wr) mem_q[idx] <= bus.write_data_in;
  end

  // Read data is sampled at the accept edge, then walks LATENCY-1 stages before entering the FIFO.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_vld = acc_rd;
      assign push_dat = rd_dat;
    end else begin : g_delay
      localparam int ST = LATENCY - 1;
      logic [ST-1:0]         dl_vld_q;
      logic [DATA_WIDTH-1:0] dl_dat_q [ST];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dl_vld_q <= '0;
          for (int i = 0; i < ST; i++) dl_dat_q[i] <= '0;
        end else begin
          dl_vld_q[0] <= acc_rd;
          dl_dat_q[0] <= rd_dat;
          for (int i = 1; i < ST; i++) begin
            dl_vld_q[i] <= dl_vld_q[i-1];
            dl_dat_q[i] <= dl_dat_q[i-1];
          end
        end
      end

      assign push_vld = dl_vld_q[ST-1];
      assign push_dat = dl_dat_q[ST-1];
    end
  endgenerate

  // Credits cover the delay line too, so a delay-line push always finds FIFO room.
  pmr_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (bus.ready_out),
    .head_vld (head_vld),
    .head_dat (head_dat)
  );

  always_comb begin
    out_d = out_q;
    if (acc_rd && !pop)      out_d = out_q + CW'(1);
    else if (!acc_rd && pop) out_d = out_q - CW'(1);
    rdy_d = (out_d < CW'(RESP_DEPTH));
  end

  // ready_in is a flop so no input reaches it combinationally; it resets low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      out_q <= out_d;
      rdy_q <= rdy_d;
    end
  end

  assign bus.ready_in  = rdy_q;
  assign bus.valid_out = head_vld;
  assign bus.data_out  = head_vld ? head_dat : '0;
endmodule
